bhand_rdy_reg: RTL

Registered-ready buffered handshake stage for the HLS middleware streaming path. It registers the backward (ready) path so that no combinational route exists from `odata_rdy` to `idata_rdy`. It also registers the forward data and valid path. It sits between two valid/ready streaming blocks wherever timing on the backpressure path fails, and sustains one transfer per cycle through a two-entry main/skid buffer.

---
 rtl/bhand_rdy_reg.sv | 104 ++++++++++
 1 files changed

// File: rtl/bhand_rdy_reg.sv
// Registered-ready buffered handshake stage with a main/skid buffer.
// The optional transfer counter is built only when BHAND_RDY_REG_COUNT_EN is defined.
module bhand_rdy_reg #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  idata,
   input  logic                   idata_vld,
   output logic                   idata_rdy,
   output logic [DATA_WIDTH-1:0]  odata,
   output logic                   odata_vld,
   input  logic                   odata_rdy,
   output logic [COUNT_WIDTH-1:0] xfer_count
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]            state_reg, state_next;
   logic [DATA_WIDTH-1:0] main_reg, main_next;
   logic [DATA_WIDTH-1:0] skid_reg, skid_next;
   logic                  vld_reg;
   logic                  rdy_reg;
   logic                  in_x;
   logic                  out_x;

   assign in_x  = idata_vld & rdy_reg;
   assign out_x = vld_reg & odata_rdy;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      case (state_reg)
         EMPTY: begin
            if (in_x) begin
               state_next = BUSY;
               main_next  = idata;
            end
         end
         BUSY: begin
            if (in_x && out_x) begin
               main_next = idata;
            end else if (in_x) begin
               state_next = FULL;
               skid_next  = idata;
            end else if (out_x) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            // ready is low here, so only the drain side can move
            if (out_x) begin
               state_next = BUSY;
               main_next  = skid_reg;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // valid and ready are decoded from the next state so both leave the flop edge clean
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= EMPTY;
         main_reg  <= '0;
         skid_reg  <= '0;
         vld_reg   <= 1'b0;
         rdy_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
         skid_reg  <= skid_next;
         vld_reg   <= (state_next != EMPTY);
         rdy_reg   <= (state_next != FULL);
      end
   end

   assign idata_rdy = rdy_reg;
   assign odata     = main_reg;
   assign odata_vld = vld_reg;

`ifdef BHAND_RDY_REG_COUNT_EN
   logic [COUNT_WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (out_x) begin
         count_reg <= count_reg + COUNT_WIDTH'(1);
      end
   end

   assign xfer_count = count_reg;
`else
   assign xfer_count = '0;
`endif

endmodule
